// File: rtl/vram_wr_scheduler.sv
// Write-port scheduler for the 480x272x9 video RAM: touch-pen pixel writes and a full-screen clear sweep.
// Optional VRAM_WR_TOUCH_QUEUE_EN buffers up to 4 touches that arrive while the clear owns the port.
module vram_wr_scheduler #(
  parameter int X_RES = 480,
  parameter int Y_RES = 272,
  parameter int ADDR_W = 17,
  parameter int PIX_W = 9,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              cclk,
  input  logic              rstb,
  input  logic              clear_screen,
  input  logic              touch_valid,
  input  logic [8:0]        touch_x,
  input  logic [8:0]        touch_y,
  input  logic [PIX_W-1:0]  touch_color,
  output logic              touch_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [PIX_W-1:0]  vram_din,
  output logic              busy,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_RES * Y_RES - 1);
  localparam logic [ADDR_W-1:0] X_STRIDE  = ADDR_W'(X_RES);
  localparam logic [9:0]        X_LIM     = 10'(X_RES);
  localparam logic [9:0]        Y_LIM     = 10'(Y_RES);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic              we_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d, sweep_cnt, cnt_d;
  logic [PIX_W-1:0]  din_d;
  logic              clr_sync_p0, clr_sync_p1, clr_sync_p2, clr_edge_p3;
  logic              touch_in_range;
  logic [ADDR_W-1:0] touch_addr;

  assign touch_in_range = touch_valid && ({1'b0, touch_x} < X_LIM) && ({1'b0, touch_y} < Y_LIM);
  assign touch_addr     = ADDR_W'(touch_y) * X_STRIDE + ADDR_W'(touch_x);

  // Button synchroniser and registered rising-edge pulse
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      clr_sync_p0 <= 1'b0;
      clr_sync_p1 <= 1'b0;
      clr_sync_p2 <= 1'b0;
      clr_edge_p3 <= 1'b0;
    end else begin
      clr_sync_p0 <= clear_screen;
      clr_sync_p1 <= clr_sync_p0;
      clr_sync_p2 <= clr_sync_p1;
      clr_edge_p3 <= clr_sync_p1 & ~clr_sync_p2;
    end
  end

`ifdef VRAM_WR_TOUCH_QUEUE_EN
  logic [ADDR_W-1:0] q_addr [4];
  logic [PIX_W-1:0]  q_din  [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        q_count;
  logic              q_full, q_empty, push, pop;

  assign q_full  = (q_count == 3'd4);
  assign q_empty = (q_count == 3'd0);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 3'd1;
        2'b01:   q_count <= q_count - 3'd1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (push) begin
      q_addr[wr_ptr] <= touch_addr;
      q_din[wr_ptr]  <= touch_color;
    end
  end
`endif

  // Output register stage
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_din   <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      vram_we    <= we_d;
      vram_addr  <= addr_d;
      vram_din   <= din_d;
      busy       <= busy_d;
      clear_done <= done_d;
      sweep_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = vram_addr;
    din_d       = vram_din;
    busy_d      = busy;
    done_d      = 1'b0;
    cnt_d       = sweep_cnt;
    touch_ready = 1'b0;
`ifdef VRAM_WR_TOUCH_QUEUE_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef VRAM_WR_TOUCH_QUEUE_EN
        touch_ready = !q_full;
        push        = touch_in_range && !q_full && (clr_edge_p3 || !q_empty);
`else
        touch_ready = 1'b1;
`endif
        // The clear overrides a touch accepted in the edge cycle
        if (clr_edge_p3) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = CLEAR_COLOR;
          cnt_d   = ADDR_W'(1);
        end
`ifdef VRAM_WR_TOUCH_QUEUE_EN
        else if (!q_empty) begin
          pop    = 1'b1;
          we_d   = 1'b1;
          addr_d = q_addr[rd_ptr];
          din_d  = q_din[rd_ptr];
        end
`endif
        else if (touch_in_range) begin
          we_d   = 1'b1;
          addr_d = touch_addr;
          din_d  = touch_color;
        end
      end
      CLEAR: begin
`ifdef VRAM_WR_TOUCH_QUEUE_EN
        touch_ready = !q_full;
        push        = touch_in_range && !q_full;
`endif
        if (vram_addr == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = sweep_cnt;
          din_d  = CLEAR_COLOR;
          cnt_d  = sweep_cnt + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vram_wr_scheduler.sv
// Directed bench for vram_wr_scheduler (default build), using a 480x16 screen so sweeps stay short.
module tb_vram_wr_scheduler;

  localparam int X_RES  = 480;
  localparam int Y_RES  = 16;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 9;
  localparam int TOTAL  = X_RES * Y_RES;

  logic              cclk, rstb, clear_screen, touch_valid;
  logic [8:0]        touch_x, touch_y;
  logic [PIX_W-1:0]  touch_color;
  logic              touch_ready, vram_we, busy, clear_done;
  logic [ADDR_W-1:0] vram_addr;
  logic [PIX_W-1:0]  vram_din;

  int compared   = 0;
  int mismatched = 0;

  vram_wr_scheduler #(
    .X_RES(X_RES), .Y_RES(Y_RES), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CLEAR_COLOR(9'h000)
  ) dut (
    .cclk(cclk), .rstb(rstb), .clear_screen(clear_screen),
    .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
    .touch_color(touch_color), .touch_ready(touch_ready),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
    .busy(busy), .clear_done(clear_done)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic touch(input int x, input int y, input logic [8:0] col);
    touch_valid = 1'b1;
    touch_x     = 9'(x);
    touch_y     = 9'(y);
    touch_color = col;
  endtask

  initial begin
    int n, cyc, writes, bad, ready_bad, done_cnt, rise_cnt;
    logic [ADDR_W-1:0] exp_addr;
    logic prev_busy;

    rstb = 1'b0; clear_screen = 1'b0; touch_valid = 1'b0;
    touch_x = '0; touch_y = '0; touch_color = '0;
    repeat (3) tick();
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_din", vram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", clear_done, 0);
    rstb = 1'b1;
    tick();
    chk("idle_ready", touch_ready, 1);

    // Single touch, latency 1, one-cycle write
    touch(10, 2, 9'h1C7);
    tick();
    touch_valid = 1'b0;
    chk("t1_we", vram_we, 1);
    chk("t1_addr", vram_addr, 970);
    chk("t1_din", vram_din, 9'h1C7);
    tick();
    chk("t1_we_off", vram_we, 0);
    chk("t1_addr_hold", vram_addr, 970);

    // Back-to-back touches at both corners
    touch(479, 15, 9'h0AB);
    tick();
    chk("b2b_a_we", vram_we, 1);
    chk("b2b_a_addr", vram_addr, 7679);
    chk("b2b_a_din", vram_din, 9'h0AB);
    touch(0, 0, 9'h155);
    tick();
    touch_valid = 1'b0;
    chk("b2b_b_we", vram_we, 1);
    chk("b2b_b_addr", vram_addr, 0);
    chk("b2b_b_din", vram_din, 9'h155);

    // Out-of-range samples are discarded
    touch(480, 5, 9'h1FF);
    tick();
    chk("oor_x_we", vram_we, 0);
    touch(3, 16, 9'h1FF);
    tick();
    chk("oor_y_we", vram_we, 0);
    touch_valid = 1'b0;
    tick();
    chk("oor_addr_hold", vram_addr, 0);
    chk("oor_din_hold", vram_din, 9'h155);

    // Clear sweep: 10-cycle press, touches injected mid-sweep
    clear_screen = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 20);
    chk("busy_latency", n, 4);
    chk("clr_first_we", vram_we, 1);
    chk("clr_first_addr", vram_addr, 0);
    chk("clr_first_din", vram_din, 0);
    writes = 1; exp_addr = 1; bad = 0; ready_bad = 0; cyc = 0;
    while (!clear_done && cyc < TOTAL + 20) begin
      if (cyc == 6) clear_screen = 1'b0;
      if (cyc >= 100 && cyc < 110) touch(5, 5, 9'h1FF);
      else touch_valid = 1'b0;
      tick();
      cyc++;
      if (vram_we) begin
        if (vram_addr !== exp_addr || vram_din !== 9'h000) bad++;
        exp_addr++;
        writes++;
      end
      if (busy && touch_ready) ready_bad++;
    end
    chk("clr_done_seen", clear_done, 1);
    chk("clr_busy_fall", busy, 0);
    chk("clr_we_after", vram_we, 0);
    chk("clr_write_count", writes, TOTAL);
    chk("clr_bad_writes", bad, 0);
    chk("clr_ready_low", ready_bad, 0);
    tick();
    chk("clr_done_pulse", clear_done, 0);
    chk("post_clr_ready", touch_ready, 1);
    touch(1, 1, 9'h038);
    tick();
    touch_valid = 1'b0;
    chk("post_clr_touch_we", vram_we, 1);
    chk("post_clr_touch_addr", vram_addr, 481);

    // Held button gives exactly one sweep
    clear_screen = 1'b1;
    done_cnt = 0; rise_cnt = 0; prev_busy = busy;
    repeat (2 * TOTAL + 100) begin
      tick();
      if (clear_done) done_cnt++;
      if (busy && !prev_busy) rise_cnt++;
      prev_busy = busy;
    end
    chk("hold_done_count", done_cnt, 1);
    chk("hold_sweep_count", rise_cnt, 1);
    clear_screen = 1'b0;
    repeat (10) tick();
    chk("hold_release_busy", busy, 0);

    // Reset at sweep address 5000
    clear_screen = 1'b1;
    repeat (10) tick();
    clear_screen = 1'b0;
    n = 0;
    while (!(vram_we && vram_addr == 17'd5000) && n < TOTAL) begin tick(); n++; end
    chk("reach_5000", vram_addr, 5000);
    rstb = 1'b0;
    #1;
    chk("mid_rst_we", vram_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", vram_addr, 0);
    repeat (3) tick();
    rstb = 1'b1;
    n = 0;
    repeat (50) begin tick(); if (busy || vram_we) n++; end
    chk("no_sweep_after_rst", n, 0);
    clear_screen = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 20);
    clear_screen = 1'b0;
    chk("restart_latency", n, 4);
    chk("restart_addr", vram_addr, 0);
    chk("restart_we", vram_we, 1);
    writes = 1; cyc = 0;
    while (!clear_done && cyc < TOTAL + 20) begin
      tick();
      cyc++;
      if (vram_we) writes++;
    end
    chk("restart_done", clear_done, 1);
    chk("restart_write_count", writes, TOTAL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
